// File: rtl/output_classifier.sv
// Purpose: argmax over a captured vector of signed fixed-point network outputs.
// Latency: result valid NUM_OUTPUTS cycles after the outputs_ready rising edge (1 cycle for a single output).
// Backpressure: result held stable until class_ready; edges seen while busy are dropped and flagged.
module output_classifier #(
    parameter int NUM_OUTPUTS    = 10,
    parameter int INTEGER_WIDTH  = 8,
    parameter int FRACTION_WIDTH = 8,
    localparam int INDEX_WIDTH   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        outputs_ready,
    input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] outputs [NUM_OUTPUTS],
    output logic                                        class_valid,
    input  logic                                        class_ready,
    output logic [INDEX_WIDTH-1:0]                      class_index,
    output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] class_score,
    output logic                                        busy,
    output logic                                        overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_OUTPUTS - 1);

    state_t                                       state;
    logic                                         ready_q;
    logic                                         trigger;
    logic [INDEX_WIDTH-1:0]                       scan_cnt;
    logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] captured [NUM_OUTPUTS];

    assign trigger = outputs_ready & ~ready_q;

    // Snapshot so later changes on the input vector cannot disturb a scan in progress.
    always_ff @(posedge clock) begin
        if (!reset && state == IDLE && trigger) begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                captured[i] <= outputs[i];
            end
        end
    end

    // class_score/class_index double as the running best during SCAN.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            scan_cnt    <= '0;
            class_valid <= 1'b0;
            class_index <= '0;
            class_score <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            ready_q <= outputs_ready;
            if (trigger && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (trigger) begin
                        class_score <= outputs[0];
                        class_index <= '0;
                        scan_cnt    <= INDEX_WIDTH'(1);
                        busy        <= 1'b1;
                        if (NUM_OUTPUTS == 1) begin
                            state       <= HOLD;
                            class_valid <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    // Strictly greater: ties keep the lowest index.
                    if (captured[scan_cnt] > class_score) begin
                        class_score <= captured[scan_cnt];
                        class_index <= scan_cnt;
                    end
                    scan_cnt <= scan_cnt + 1'b1;
                    if (scan_cnt == LAST_INDEX) begin
                        state       <= HOLD;
                        class_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (class_ready) begin
                        state       <= IDLE;
                        class_valid <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    class_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_classifier.sv
// Directed bench for output_classifier with a result scoreboard on the class handshake.
module tb_output_classifier;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] score;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              outputs_ready;
    logic signed [7:-8] outs [10];
    logic              class_valid;
    logic              class_ready;
    logic [3:0]        class_index;
    logic signed [7:-8] class_score;
    logic              busy;
    logic              overrun;

    int   checks    = 0;
    int   failures  = 0;
    int   hs_count  = 0;
    int   hs_before = 0;
    exp_t sb_q [$];

    logic [15:0] vec_a [10] = '{16'h0080, 16'h0140, 16'hFE00, 16'h03C0, 16'h0000,
                                16'h0380, 16'h0100, 16'hFFC0, 16'h0200, 16'h00C0};
    logic [15:0] vec_b [10] = '{16'h0100, 16'h0100, 16'hFE00, 16'h0100, 16'h0100,
                                16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0100};

    output_classifier #(
        .NUM_OUTPUTS   (10),
        .INTEGER_WIDTH (8),
        .FRACTION_WIDTH(8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .outputs_ready(outputs_ready),
        .outputs      (outs),
        .class_valid  (class_valid),
        .class_ready  (class_ready),
        .class_index  (class_index),
        .class_score  (class_score),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_a();
        for (int i = 0; i < 10; i++) outs[i] = vec_a[i];
    endtask

    task automatic load_b();
        for (int i = 0; i < 10; i++) outs[i] = vec_b[i];
    endtask

    task automatic load_const(input logic [15:0] v);
        for (int i = 0; i < 10; i++) outs[i] = v;
    endtask

    // Scoreboard: every accepted result must match the oldest pending expectation.
    always @(negedge clock) begin
        if (!reset && class_valid && class_ready) begin
            exp_t e;
            hs_count++;
            checks++;
            assert (sb_q.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected_result observed=%0h expected=none", class_index);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_index", {12'h0, class_index}, {12'h0, e.idx});
                chk("sb_score", class_score, e.score);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        outputs_ready = 1'b0;
        class_ready   = 1'b0;
        load_const(16'h0000);
        repeat (3) step();
        reset = 1'b0;
        chk("rst_valid",   class_valid, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_index",   class_index, 0);
        chk("rst_score",   class_score, 0);
        step();

        // Mixed vector, input changed after capture.
        load_a();
        class_ready   = 1'b1;
        outputs_ready = 1'b1;
        sb_q.push_back('{idx: 4'd3, score: 16'h03C0});
        step();
        chk("a_busy_t1",  busy, 1);
        chk("a_valid_t1", class_valid, 0);
        load_const(16'h7F00);
        repeat (8) step();
        chk("a_valid_t9", class_valid, 0);
        step();
        chk("a_valid_t10", class_valid, 1);
        chk("a_index",     class_index, 3);
        chk("a_score",     class_score, 16'h03C0);
        step();
        chk("a_valid_t11", class_valid, 0);
        chk("a_busy_t11",  busy, 0);
        outputs_ready = 1'b0;
        step();

        // All -1.0 ties, with backpressure.
        load_const(16'hFF00);
        class_ready   = 1'b0;
        outputs_ready = 1'b1;
        sb_q.push_back('{idx: 4'd0, score: 16'hFF00});
        repeat (10) step();
        for (int i = 0; i < 5; i++) begin
            chk("b_hold_valid", class_valid, 1);
            chk("b_hold_index", class_index, 0);
            chk("b_hold_score", class_score, 16'hFF00);
            step();
        end
        chk("b_valid_t15", class_valid, 1);
        class_ready = 1'b1;
        step();
        chk("b_valid_after_hs", class_valid, 0);
        outputs_ready = 1'b0;
        step();

        // Second edge during SCAN.
        load_a();
        outputs_ready = 1'b1;
        sb_q.push_back('{idx: 4'd3, score: 16'h03C0});
        hs_before = hs_count;
        repeat (3) step();
        outputs_ready = 1'b0;
        step();
        outputs_ready = 1'b1;
        chk("c_overrun_t4", overrun, 0);
        step();
        chk("c_overrun_t5", overrun, 1);
        chk("c_busy_t5",    busy, 1);
        repeat (5) step();
        chk("c_valid_t10", class_valid, 1);
        chk("c_index",     class_index, 3);
        repeat (16) step();
        chk("c_one_result",   16'(hs_count - hs_before), 1);
        chk("c_overrun_held", overrun, 1);
        chk("c_busy_idle",    busy, 0);
        outputs_ready = 1'b0;
        step();

        // Reset mid-SCAN, then an edge right after reset release.
        load_a();
        outputs_ready = 1'b1;
        hs_before = hs_count;
        repeat (5) step();
        reset         = 1'b1;
        outputs_ready = 1'b0;
        step();
        reset = 1'b0;
        chk("d_valid",   class_valid, 0);
        chk("d_busy",    busy, 0);
        chk("d_overrun", overrun, 0);
        chk("d_index",   class_index, 0);
        chk("d_score",   class_score, 0);
        load_b();
        outputs_ready = 1'b1;
        sb_q.push_back('{idx: 4'd6, score: 16'h0200});
        repeat (9) step();
        chk("d_valid_e9", class_valid, 0);
        step();
        chk("d_valid_e10", class_valid, 1);
        chk("d_index_e10", class_index, 6);
        chk("d_score_e10", class_score, 16'h0200);
        chk("d_no_abandoned_result", 16'(hs_count - hs_before), 0);
        step();
        outputs_ready = 1'b0;
        step();

        // Level held high for 30 cycles.
        load_a();
        outputs_ready = 1'b1;
        sb_q.push_back('{idx: 4'd3, score: 16'h03C0});
        hs_before = hs_count;
        repeat (30) step();
        outputs_ready = 1'b0;
        repeat (3) step();
        chk("e_one_result", 16'(hs_count - hs_before), 1);
        chk("e_overrun",    overrun, 0);
        chk("sb_drained",   16'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_classifier.md
OUTPUT_CLASSIFIER -- requirements
Module: output_classifier

Interface
- REQ-001: Parameter NUM_OUTPUTS, default 10; number of network output neurons scanned; legal range 1 to 256.
- REQ-002: Parameter INTEGER_WIDTH, default 8; integer bits of each signed fixed-point output.
- REQ-003: Parameter FRACTION_WIDTH, default 8; fraction bits of each signed fixed-point output.
- REQ-004: Port clock, input, 1 bit; single clock; all logic on its rising edge.
- REQ-005: Port reset, input, 1 bit; synchronous, active-high reset.
- REQ-006: Port outputs_ready, input, 1 bit; level from neural_network, high while outputs are valid.
- REQ-007: Port outputs, input, NUM_OUTPUTS x signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]; network output vector.
- REQ-008: Port class_valid, output, 1 bit; a classification result is presented.
- REQ-009: Port class_ready, input, 1 bit; consumer accepts the result.
- REQ-010: Port class_index, output, max(1,$clog2(NUM_OUTPUTS)) bits, unsigned; index of the winning output.
- REQ-011: Port class_score, output, signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]; value of the winning output.
- REQ-012: Port busy, output, 1 bit; high in SCAN or HOLD.
- REQ-013: Port overrun, output, 1 bit; sticky flag for a result that was dropped.

Function
- REQ-014: FSM states IDLE, SCAN and HOLD.
- REQ-015: Trigger = rising edge of outputs_ready, meaning the current sample is 1 and the registered previous sample is 0.
- REQ-016: Trigger in IDLE during cycle T:
  - all NUM_OUTPUTS elements are copied into an internal register array;
  - best score = element 0, best index = 0, scan counter = 1;
  - next state SCAN, or HOLD when NUM_OUTPUTS = 1.
- REQ-017: SCAN compares one captured element per cycle (element k), as a full-width signed compare.
  - Best is replaced only if element k > best (strictly greater).
  - Ties therefore keep the lowest index.
- REQ-018: After element NUM_OUTPUTS-1 is compared, next state is HOLD.
  - class_valid goes high in cycle T+NUM_OUTPUTS.
  - For NUM_OUTPUTS = 1 it goes high in cycle T+1.
- REQ-019: In HOLD, class_valid, class_index and class_score stay stable until class_valid and class_ready are both high in the same cycle.
- REQ-020: On that handshake, the next state is IDLE and class_valid is low in the following cycle.
- REQ-021: class_ready has no effect outside HOLD.
- REQ-022: class_index and class_score keep their last values after the handshake; they are meaningful only while class_valid is high.
- REQ-023: A trigger in SCAN or HOLD is not captured and sets overrun = 1 on the next cycle.
  - The result in progress is unaffected.
- REQ-024: overrun stays high until reset.
- REQ-025: A trigger in the same cycle as the HOLD handshake is treated as an overrun; it is not captured.
- REQ-026: Changes on outputs after the capture cycle do not affect the result in progress.
- REQ-027: outputs_ready held high continuously produces exactly one capture; a new capture needs outputs_ready to go low and then high again.
- REQ-028: busy = 1 exactly when the state is SCAN or HOLD.

Reset
- REQ-029: When reset is sampled high:
  - state returns to IDLE;
  - class_valid, busy and overrun become 0;
  - class_index and class_score become 0;
  - scan counter becomes 0;
  - the registered previous outputs_ready becomes 0.
- REQ-030: Reset in any state, including mid-SCAN or in HOLD with class_valid high, abandons the operation with no result presented.
- REQ-031: If outputs_ready is high in the first cycle after reset is released, that is a trigger.
- REQ-032: Reset has priority over every other input in the same cycle.

Verification
- REQ-033: NUM_OUTPUTS=10, Q8.8; outputs = {0.5, 1.25, -2.0, 3.75, 0.0, 3.5, 1.0, -0.25, 2.0, 0.75}; outputs_ready rises at cycle T; class_ready=1 -> class_valid at T+10, class_index=3, class_score=0x03C0, IDLE at T+11.
- REQ-034: All outputs = -1.0 (0xFF00) -> class_index=0, class_score=0xFF00 (tie keeps lowest index; signed compare).
- REQ-035: Backpressure: class_ready=0 for 5 cycles after class_valid -> index and score stable and valid high throughout; class_ready=1 -> valid low on the next cycle.
- REQ-036: outputs_ready pulsed low then high at T+4 during SCAN -> first result unchanged; overrun=1 from T+5 until reset; no second result.
- REQ-037: Reset asserted at T+5 mid-SCAN -> next cycle valid=0, busy=0, overrun=0, index=0, score=0; a new edge then yields a correct result at edge+10.
- REQ-038: outputs_ready held high for 30 cycles -> exactly one class_valid handshake.
